// File: rtl/axil_regbank_gen2.sv
// axil_regbank_gen2: parametrised AXI4-Lite register bank with RW, RO and W1C registers
module axil_regbank_gen2 #(
  parameter int NUM_REGS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]            wr_strobe
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW = ADDR_WIDTH - OFF;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic aw_held, w_held, aw_hs, w_hs, ar_hs, fire, wr_ok, rd_err;
  logic [ADDR_WIDTH-1:0] aw_addr, wa;
  logic [DATA_WIDTH-1:0] w_data, wd, bm, rd_val, rdata_q;
  logic [SW-1:0] w_strb, ws;
  logic [IW-1:0] w_idx, r_idx;
  logic [1:0] bresp_q, rresp_q;
  logic unused;
  assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, hw_in, hw_set};
  assign S_AXI_AWREADY = w_state == W_IDLE && !aw_held;
  assign S_AXI_WREADY = w_state == W_IDLE && !w_held;
  assign S_AXI_BVALID = w_state == W_RESP;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_ARREADY = r_state == R_IDLE;
  assign S_AXI_RVALID = r_state == R_DATA;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  // A write completes on the edge where the later of address/data arrives, using bus values directly
  assign fire = (aw_held || aw_hs) && (w_held || w_hs);
  assign wa = aw_held ? aw_addr : S_AXI_AWADDR;
  assign wd = w_held ? w_data : S_AXI_WDATA;
  assign ws = w_held ? w_strb : S_AXI_WSTRB;
  assign w_idx = wa[ADDR_WIDTH-1:OFF];
  assign r_idx = S_AXI_ARADDR[ADDR_WIDTH-1:OFF];
  for (genvar k = 0; k < SW; k++) begin : g_bm
    assign bm[k*8 +: 8] = {8{ws[k]}};
  end
  always_comb begin
    wr_ok = 1'b0;
    rd_err = 1'b1;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_idx) == i) wr_ok = !RO_MASK[i];
      if (int'(r_idx) == i) begin
        rd_err = 1'b0;
        rd_val = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : reg_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_comb begin
    w_next = w_state == W_IDLE ? (fire ? W_RESP : W_IDLE) : (S_AXI_BREADY ? W_IDLE : W_RESP);
    r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_DATA);
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      bresp_q <= 2'b00;
    end else if (fire) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      bresp_q <= wr_ok ? 2'b00 : 2'b10;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else if (ar_hs) begin
      rdata_q <= rd_val;
      rresp_q <= rd_err ? 2'b10 : 2'b00;
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] r;
    logic s, hit;
    assign hit = fire && wr_ok && int'(w_idx) == i;
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r;
    assign wr_strobe[i] = s;
    // hw_set is ORed after the software clear so a coincident set wins
    always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
        r <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        s <= 1'b0;
      end else begin
        s <= hit;
        r <= RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH]
           : W1C_MASK[i] ? (r & ~(hit ? wd & bm : '0)) | hw_set[i*DATA_WIDTH +: DATA_WIDTH]
           : hit ? (r & ~bm) | (wd & bm) : r;
      end
  end
endmodule

// File: tb/tb_axil_regbank_gen2.sv
// tb_axil_regbank_gen2: directed and randomized checks of axil_regbank_gen2 against an array model
module tb_axil_regbank_gen2;
  localparam int N = 8;
  localparam logic [255:0] RV = {32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'hDEADBEEF, 32'h00005A5A, 32'h0, 32'h0};
  logic clk = 1'b0, rst_n = 1'b1;
  logic [5:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [255:0] reg_out, hw_in, hw_set;
  logic [7:0] wr_strobe;
  int checks = 0, errors = 0;
  logic [31:0] m [N];
  logic [31:0] set_on_fire = '0;

  always #5 clk = ~clk;

  axil_regbank_gen2 #(.NUM_REGS(N), .DATA_WIDTH(32), .ADDR_WIDTH(6), .RO_MASK(8'h80),
                      .W1C_MASK(8'h02), .RESET_VAL(RV)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .hw_in(hw_in), .hw_set(hw_set), .wr_strobe(wr_strobe));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[k*8 +: 8] = {8{s[k]}};
    return b;
  endfunction

  function automatic logic [255:0] exp_regs();
    logic [255:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = (i == 7) ? hw_in[7*32 +: 32] : m[i];
    return v;
  endfunction

  // reg 7 is read-only (hw_in), reg 1 is write-1-to-clear, the rest read/write
  function automatic logic [1:0] model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[5:2]);
    if (idx >= N || idx == 7) return 2'b10;
    if (idx == 1) m[1] = m[1] & ~(d & bmask(s));
    else m[idx] = (m[idx] & ~bmask(s)) | (d & bmask(s));
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a[5:2]);
    r = (idx >= N) ? 2'b10 : 2'b00;
    d = (idx >= N) ? 32'h0 : (idx == 7) ? hw_in[7*32 +: 32] : m[idx];
  endfunction

  task automatic do_write(input string tag, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_stall);
    bit aw_done = 0, w_done = 0;
    int cyc = 0;
    logic [1:0] er;
    logic [7:0] es;
    er = model_write(a, d, s);
    m[1] = m[1] | set_on_fire;
    es = (er == 2'b00) ? 8'(1 << a[5:2]) : 8'h00;
    bready = 1'b0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr = a;
      wvalid = !w_done && cyc >= w_dly;
      wdata = d;
      wstrb = s;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      if (aw_done && w_done) hw_set[63:32] = set_on_fire;
      cyc++;
    end
    chk({tag, " handshake"}, 256'(aw_done && w_done), 256'(1));
    bready = (b_stall == 0);
    @(negedge clk);
    awvalid = 0;
    wvalid = 0;
    hw_set = '0;
    chk({tag, " bvalid"}, 256'(bvalid), 256'(1));
    chk({tag, " bresp"}, 256'(bresp), 256'(er));
    chk({tag, " wr_strobe"}, 256'(wr_strobe), 256'(es));
    for (int i = 0; i < b_stall; i++) begin
      @(negedge clk);
      chk({tag, " stall bvalid"}, 256'(bvalid), 256'(1));
      chk({tag, " stall bresp"}, 256'(bresp), 256'(er));
      chk({tag, " stall aw/wready"}, 256'({awready, wready}), 256'(0));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, " bvalid drop"}, 256'(bvalid), 256'(0));
    chk({tag, " strobe pulse"}, 256'(wr_strobe), 256'(0));
    chk({tag, " reg_out"}, reg_out, exp_regs());
  endtask

  task automatic do_read(input string tag, input logic [5:0] a, input int r_stall);
    logic [31:0] ed;
    logic [1:0] er;
    model_read(a, ed, er);
    @(negedge clk);
    arvalid = 1'b1;
    araddr = a;
    rready = 1'b0;
    chk({tag, " arready"}, 256'(arready), 256'(1));
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, " rvalid"}, 256'(rvalid), 256'(1));
    chk({tag, " rdata"}, 256'(rdata), 256'(ed));
    chk({tag, " rresp"}, 256'(rresp), 256'(er));
    for (int i = 0; i < r_stall; i++) begin
      @(negedge clk);
      chk({tag, " stall rvalid/rresp/arready"}, 256'({rvalid, rresp, arready}), 256'({1'b1, er, 1'b0}));
      chk({tag, " stall rdata"}, 256'(rdata), 256'(ed));
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, " rvalid drop"}, 256'(rvalid), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ra;
    for (int i = 0; i < N; i++) begin
      hw_in[i*32 +: 32] = $urandom;
      m[i] = RV[i*32 +: 32];
    end
    hw_set = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset readies", 256'({awready, wready, arready}), 256'(3'b111));
    chk("reset valids", 256'({bvalid, rvalid}), 256'(0));
    chk("reset resp/rdata", 256'({bresp, rresp, rdata}), 256'(0));
    chk("reset strobe", 256'(wr_strobe), 256'(0));
    chk("reset reg_out", reg_out, RV);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_write("seq write", 6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read("seq read", 6'(i * 4), 0);
    do_write("aw first", 6'h08, 32'h0BADCAFE, 4'hF, 0, 3, 0);
    do_write("w first", 6'h0C, 32'h600DF00D, 4'hF, 3, 0, 0);
    do_read("aw first rd", 6'h08, 0);
    do_read("w first rd", 6'h0C, 0);
    do_write("full reg0", 6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write("strb reg0", 6'h01, 32'h11223344, 4'h5, 0, 0, 0);
    do_read("strb rd", 6'h00, 0);
    @(negedge clk);
    hw_set[63:32] = 32'h000000F0;
    m[1] = m[1] | 32'h000000F0;
    @(negedge clk);
    hw_set = '0;
    do_read("w1c set", 6'h04, 0);
    do_write("w1c clr", 6'h04, 32'h00000030, 4'hF, 0, 0, 0);
    do_read("w1c clr rd", 6'h04, 0);
    set_on_fire = 32'h00000040;
    do_write("w1c race", 6'h04, 32'h00000040, 4'hF, 0, 0, 0);
    set_on_fire = '0;
    do_read("w1c race rd", 6'h04, 0);
    do_write("oob write", 6'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write("ro write", 6'h1C, 32'h12345678, 4'hF, 1, 0, 0);
    do_read("oob read", 6'h20, 0);
    do_read("ro read", 6'h1C, 0);
    do_write("stall write", 6'h14, 32'h5555AAAA, 4'h3, 0, 0, 10);
    do_read("stall read", 6'h14, 10);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) hw_in[7*32 +: 32] = $urandom;
      ra = 6'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write("rand write", ra, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        do_read("rand read", ra, int'($urandom_range(0, 2)));
    end
    @(negedge clk);
    awvalid = 1'b1;
    wvalid = 1'b1;
    awaddr = 6'h00;
    wdata = 32'h13579BDF;
    wstrb = 4'hF;
    arvalid = 1'b1;
    araddr = 6'h08;
    bready = 1'b0;
    rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    arvalid = 1'b0;
    chk("pre-reset valids", 256'({bvalid, rvalid}), 256'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valids", 256'({bvalid, rvalid}), 256'(0));
    chk("async reset readies", 256'({awready, wready, arready}), 256'(3'b111));
    chk("async reset regs", reg_out, RV);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) m[i] = RV[i*32 +: 32];
    do_read("post reset rd", 6'h0C, 0);
    do_write("post reset wr", 6'h18, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
